// File: rtl/xalu_sched_if.sv
// ----------------------------------------------------------------------------
// xalu_sched_if
// Bundle between the E stage / hazard unit and the HI/LO multiply-divide
// sequencer.
//   E_Start  op presented in E (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//            5 mthi, 6 mtlo, 7 reserved)
//   E_Flush  kills the E instruction this cycle
//   E_A/E_B  forwarded rs/rt operands
//   D_HiLo   instruction in D touches HI/LO
//   E_Busy   sequencer is running a multi-cycle op
//   Stall    HI/LO structural stall to the hazard unit
//   HI/LO    architectural HI/LO registers
// master = pipeline side (drives requests), slave = sequencer.
// ----------------------------------------------------------------------------
interface xalu_sched_if;
    logic [2:0]  E_Start;
    logic        E_Flush;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_HiLo;
    logic        E_Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output E_Start, E_Flush, E_A, E_B, D_HiLo,
        input  E_Busy, Stall, HI, LO
    );

    modport slave (
        input  E_Start, E_Flush, E_A, E_B, D_HiLo,
        output E_Busy, Stall, HI, LO
    );
endinterface

// File: rtl/xalu_sched.sv
// ----------------------------------------------------------------------------
// xalu_sched
// Multiply/divide sequencer for the E stage. Accepts mult/multu/div/divu and
// mthi/mtlo, owns HI/LO, models a fixed busy latency per op class and raises
// the HI/LO structural stall.
//   clk    core clock, rising edge
//   reset  asynchronous active-low reset; clears HI/LO and aborts any op
//   bus    xalu_sched_if.slave (E_Start, E_Flush, E_A, E_B, D_HiLo in;
//          E_Busy, Stall, HI, LO out)
// ----------------------------------------------------------------------------
module xalu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    xalu_sched_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;

    logic        is_md;
    logic        wr_d;
    logic [63:0] res_d;

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic signed [31:0] sa, sb_safe, squot, srem;
    logic        [31:0] ub_safe, uquot, urem;
    logic               div_ovf;

    assign is_md = (bus.E_Start >= OP_MULT) && (bus.E_Start <= OP_DIVU);

    // Result datapath works off the latched operands and is consumed only on
    // the final busy edge. Divisors are forced to 1 for divide-by-zero (result
    // discarded) and for INT_MIN/-1, where x/1 already yields the required
    // LO=0x80000000, HI=0 without overflowing the signed divider.
    assign sprod   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign uprod   = {32'd0, a_q} * {32'd0, b_q};
    assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign sa      = $signed(a_q);
    assign sb_safe = ((b_q == 32'd0) || div_ovf) ? 32'sd1 : $signed(b_q);
    assign squot   = sa / sb_safe;
    assign srem    = sa % sb_safe;
    assign ub_safe = (b_q == 32'd0) ? 32'd1 : b_q;
    assign uquot   = a_q / ub_safe;
    assign urem    = a_q % ub_safe;

    always_comb begin
        res_d = {hi_q, lo_q};
        wr_d  = 1'b0;
        case (op_q)
            OP_MULT:  begin res_d = sprod; wr_d = 1'b1; end
            OP_MULTU: begin res_d = uprod; wr_d = 1'b1; end
            OP_DIV:   begin res_d = {srem, squot}; wr_d = (b_q != 32'd0); end
            OP_DIVU:  begin res_d = {urem, uquot}; wr_d = (b_q != 32'd0); end
            default:  begin res_d = {hi_q, lo_q}; wr_d = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.E_Flush) begin
                        if (is_md) begin
                            op_q    <= bus.E_Start;
                            a_q     <= bus.E_A;
                            b_q     <= bus.E_B;
                            cnt_q   <= (bus.E_Start <= OP_MULTU) ? 4'(MULT_CYCLES)
                                                                 : 4'(DIV_CYCLES);
                            state_q <= RUN;
                        end else if (bus.E_Start == OP_MTHI) begin
                            hi_q <= bus.E_A;
                        end else if (bus.E_Start == OP_MTLO) begin
                            lo_q <= bus.E_A;
                        end
                    end
                end
                RUN: begin
                    // Requests and flushes are ignored while running.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (wr_d) begin
                            hi_q <= res_d[63:32];
                            lo_q <= res_d[31:0];
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.E_Busy = (state_q == RUN);
    // Purely combinational; E_Flush deliberately does not mask it.
    assign bus.Stall  = bus.D_HiLo && ((state_q == RUN) || is_md);
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
endmodule

// File: tb/tb_xalu_sched.sv
module tb_xalu_sched;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    xalu_sched_if bus();

    xalu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a multi-cycle op for one cycle, then count busy cycles (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cycles);
        bus.E_Start = op;
        bus.E_A     = a;
        bus.E_B     = b;
        tick();
        bus.E_Start = 3'd0;
        #1;
        cycles = 0;
        while (bus.E_Busy && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        bus.E_Start = op;
        bus.E_A     = v;
        tick();
        bus.E_Start = 3'd0;
        #1;
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        reset       = 1'b0;
        bus.E_Start = 3'd1;
        bus.E_Flush = 1'b0;
        bus.E_A     = 32'd0;
        bus.E_B     = 32'd0;
        bus.D_HiLo  = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.E_Busy), 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk("rst_stall_comb", 32'(bus.Stall), 32'd1);
        bus.E_Start = 3'd0;
        bus.D_HiLo  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // mult / multu
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, n);
        chk("mult_busy", 32'(n), 32'd5);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, n);
        chk("multu_busy", 32'(n), 32'd5);
        chk("multu_hi", bus.HI, 32'h0000_0001);
        chk("multu_lo", bus.LO, 32'hFFFF_FFFE);

        // div / divu
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_busy", 32'(n), 32'd10);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'd2, n);
        chk("divu_busy", 32'(n), 32'd10);
        chk("divu_lo", bus.LO, 32'd3);
        chk("divu_hi", bus.HI, 32'd1);

        // mthi/mtlo, divide by zero, overflow
        mt(3'd5, 32'h11);
        mt(3'd6, 32'h22);
        chk("mthi", bus.HI, 32'h11);
        chk("mtlo", bus.LO, 32'h22);
        run_op(3'd3, 32'd123, 32'd0, n);
        chk("div0_busy", 32'(n), 32'd10);
        chk("div0_hi", bus.HI, 32'h11);
        chk("div0_lo", bus.LO, 32'h22);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("ovf_lo", bus.LO, 32'h8000_0000);
        chk("ovf_hi", bus.HI, 32'd0);

        // Stall window: 1 request cycle + 10 busy cycles
        bus.D_HiLo  = 1'b1;
        bus.E_Start = 3'd3;
        bus.E_A     = 32'd100;
        bus.E_B     = 32'd7;
        #1;
        n = bus.Stall ? 1 : 0;
        tick();
        bus.E_Start = 3'd0;
        #1;
        while (bus.Stall && n < 100) begin
            n++;
            tick();
        end
        chk("stall_cycles", 32'(n), 32'd11);
        chk("stall_div_lo", bus.LO, 32'd14);
        chk("stall_div_hi", bus.HI, 32'd2);
        bus.E_Start = 3'd5;
        bus.E_A     = 32'h55;
        #1;
        chk("stall_mthi", 32'(bus.Stall), 32'd0);
        tick();
        bus.E_Start = 3'd0;
        bus.D_HiLo  = 1'b0;
        #1;
        chk("mthi_55", bus.HI, 32'h55);

        // mthi during busy is ignored (div by zero keeps HI untouched)
        mt(3'd5, 32'h77);
        bus.E_Start = 3'd3;
        bus.E_A     = 32'd5;
        bus.E_B     = 32'd0;
        tick();
        bus.E_Start = 3'd5;
        bus.E_A     = 32'h0000_DEAD;
        n = 0;
        while (bus.E_Busy && n < 100) begin
            n++;
            tick();
            bus.E_Start = 3'd0;
        end
        chk("ign_busy", 32'(n), 32'd10);
        chk("ign_hi", bus.HI, 32'h77);
        chk("ign_lo", bus.LO, 32'd14);

        // start with flush
        bus.E_Start = 3'd1;
        bus.E_Flush = 1'b1;
        bus.E_A     = 32'd9;
        bus.E_B     = 32'd9;
        tick();
        bus.E_Start = 3'd0;
        bus.E_Flush = 1'b0;
        #1;
        chk("flush_busy", 32'(bus.E_Busy), 32'd0);
        tick();
        chk("flush_busy2", 32'(bus.E_Busy), 32'd0);
        chk("flush_hi", bus.HI, 32'h77);
        chk("flush_lo", bus.LO, 32'd14);

        // async reset mid-run
        bus.E_Start = 3'd3;
        bus.E_A     = 32'd100;
        bus.E_B     = 32'd7;
        tick();
        bus.E_Start = 3'd0;
        tick();
        tick();
        chk("pre_rst_busy", 32'(bus.E_Busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.E_Busy), 32'd0);
        chk("arst_hi", bus.HI, 32'd0);
        chk("arst_lo", bus.LO, 32'd0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_op(3'd1, 32'd6, 32'd7, n);
        chk("post_busy", 32'(n), 32'd5);
        chk("post_lo", bus.LO, 32'd42);
        chk("post_hi", bus.HI, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
